// File: rtl/ecc_pkg.sv
// ecc_pkg: definitions shared by the ECC fault monitor and its syndrome decoder.
//   - Hamming bit positions of the 6-bit codeword {d6,d5,p4,d3,p2,p1}
//   - syndrome() : 3-bit syndrome of a stored codeword
//   - onehot_pos(): one-hot rewrite mask for a syndrome (bit i-1 = position i)
//   - fsm_state_e : scrub FSM states
package ecc_pkg;

    localparam int CODE_W = 6;
    localparam int CNT_W  = 3;
    localparam int SYN_W  = 3;

    // Index into the codeword vector of each Hamming position (position - 1).
    localparam int POS_P1 = 0;
    localparam int POS_P2 = 1;
    localparam int POS_D3 = 2;
    localparam int POS_P4 = 3;
    localparam int POS_D5 = 4;
    localparam int POS_D6 = 5;

    localparam logic [SYN_W-1:0] SYN_NONE   = 3'd0;
    // Position 7 does not exist in a 6-bit word, so this syndrome is a
    // multi-bit upset that cannot be corrected.
    localparam logic [SYN_W-1:0] SYN_UNCORR = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ALARM = 2'd2
    } fsm_state_e;

    // Same parity equations as the counter's parity generator.
    function automatic logic [SYN_W-1:0] syndrome(input logic [CODE_W-1:0] code);
        logic s1;
        logic s2;
        logic s4;
        s1 = code[POS_P1] ^ code[POS_D3] ^ code[POS_D5];
        s2 = code[POS_P2] ^ code[POS_D3] ^ code[POS_D6];
        s4 = code[POS_P4] ^ code[POS_D5] ^ code[POS_D6];
        return {s4, s2, s1};
    endfunction

    function automatic logic [CODE_W-1:0] onehot_pos(input logic [SYN_W-1:0] syn);
        logic [CODE_W-1:0] mask;
        case (syn)
            3'd1:    mask = 6'b000001;
            3'd2:    mask = 6'b000010;
            3'd3:    mask = 6'b000100;
            3'd4:    mask = 6'b001000;
            3'd5:    mask = 6'b010000;
            3'd6:    mask = 6'b100000;
            default: mask = 6'b000000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ecc_syndrome.sv
// ecc_syndrome: combinational syndrome decode of the stored codeword.
// Ports:
//   i_code          in  6  stored codeword {d6,d5,p4,d3,p2,p1}
//   o_syn           out 3  syndrome {s4,s2,s1} (0 = clean, 1..6 = bad position)
//   o_mask          out 6  one-hot rewrite mask for the bad position (0 otherwise)
//   o_correctable   out 1  syndrome names a real position 1..6
//   o_uncorrectable out 1  syndrome is 7
module ecc_syndrome
    import ecc_pkg::*;
(
    input  logic [CODE_W-1:0] i_code,
    output logic [SYN_W-1:0]  o_syn,
    output logic [CODE_W-1:0] o_mask,
    output logic              o_correctable,
    output logic              o_uncorrectable
);

    logic [SYN_W-1:0] w_syn;

    assign w_syn           = syndrome(i_code);
    assign o_syn           = w_syn;
    assign o_mask          = onehot_pos(w_syn);
    assign o_correctable   = (w_syn != SYN_NONE) && (w_syn != SYN_UNCORR);
    assign o_uncorrectable = (w_syn == SYN_UNCORR);

endmodule

// File: rtl/ecc_fault_monitor.sv
// ecc_fault_monitor: watches the Hamming-protected mod-8 counter, logs and
// counts single-bit upsets, checks that the count moves by exactly one step
// per update, requests scrubs of upset bits and raises a sticky alarm on
// anything it cannot repair.
// Ports:
//   clock       in  1          system clock, rising edge
//   reset       in  1          synchronous active-high reset
//   code_in     in  6          stored codeword {d6,d5,p4,d3,p2,p1}
//   count_in    in  3          corrected count {q6,q5,q3}
//   updown      in  1          direction of this update (1 = up)
//   valid_in    in  1          code_in/count_in are a new post-update sample
//   scrub_ack   in  1          upstream has rewritten the bits in scrub_mask
//   err_valid   out 1          one-cycle pulse per logged single-bit error
//   err_pos     out 3          position of last logged error
//   err_cnt     out ERR_CNT_W  saturating corrected-error count
//   scrub_req   out 1          rewrite request for scrub_mask
//   scrub_mask  out 6          one-hot bit to rewrite (bit i-1 = position i)
//   seq_err     out 1          sticky step violation flag
//   alarm       out 1          sticky fatal indication
module ecc_fault_monitor
    import ecc_pkg::*;
#(
    parameter int ERR_CNT_W    = 8,
    parameter int ALARM_THRESH = 16,
    parameter int ACK_TIMEOUT  = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [CODE_W-1:0]    code_in,
    input  logic [CNT_W-1:0]     count_in,
    input  logic                 updown,
    input  logic                 valid_in,
    input  logic                 scrub_ack,
    output logic                 err_valid,
    output logic [SYN_W-1:0]     err_pos,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 scrub_req,
    output logic [CODE_W-1:0]    scrub_mask,
    output logic                 seq_err,
    output logic                 alarm
);

    localparam int TMR_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;
    // The timer holds the number of un-acked cycles already spent in REQ, so
    // the request is abandoned on the cycle that would make it ACK_TIMEOUT.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

    fsm_state_e           r_state;
    logic [TMR_W-1:0]     r_timer;
    logic                 r_err_valid;
    logic [SYN_W-1:0]     r_err_pos;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 r_scrub_req;
    logic [CODE_W-1:0]    r_scrub_mask;
    logic                 r_seq_err;
    logic                 r_alarm;
    logic                 r_hist_valid;
    logic [CNT_W-1:0]     r_hist_cnt;
    logic                 r_hist_updown;

    logic [SYN_W-1:0]     w_syn;
    logic [CODE_W-1:0]    w_mask;
    logic                 w_correctable;
    logic                 w_uncorrectable;
    logic                 w_sample_corr;
    logic [CNT_W-1:0]     w_step_exp;
    logic                 w_step_bad;
    logic [ERR_CNT_W-1:0] w_err_cnt_nxt;
    logic                 w_thresh;
    logic                 w_timeout;
    logic                 w_alarm_src;

    ecc_syndrome u_syndrome (
        .i_code          (code_in),
        .o_syn           (w_syn),
        .o_mask          (w_mask),
        .o_correctable   (w_correctable),
        .o_uncorrectable (w_uncorrectable)
    );

    assign w_sample_corr = valid_in && w_correctable;

    // 3-bit arithmetic makes the 7->0 and 0->7 wraps legal for free.
    assign w_step_exp = r_hist_updown ? (r_hist_cnt + 3'd1) : (r_hist_cnt - 3'd1);
    assign w_step_bad = valid_in && r_hist_valid && (count_in != w_step_exp);

    assign w_err_cnt_nxt = (w_sample_corr && (r_err_cnt != ERR_CNT_MAX))
                         ? r_err_cnt + ERR_CNT_W'(1) : r_err_cnt;

    // Compared against the next count so the alarm rises together with the
    // error count crossing the threshold.
    assign w_thresh  = (w_err_cnt_nxt >= ERR_CNT_W'(ALARM_THRESH));
    assign w_timeout = (r_state == REQ) && !scrub_ack && (r_timer == TMR_LAST);

    assign w_alarm_src = (valid_in && w_uncorrectable) || w_step_bad || w_thresh || w_timeout;

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others, whatever the order
    // of the statements below.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            r_err_valid   <= 1'b0;
            r_err_pos     <= '0;
            r_err_cnt     <= '0;
            r_scrub_req   <= 1'b0;
            r_scrub_mask  <= '0;
            r_seq_err     <= 1'b0;
            r_alarm       <= 1'b0;
            r_hist_valid  <= 1'b0;
            r_hist_cnt    <= '0;
            r_hist_updown <= 1'b0;
        end else begin
            // Logging and counting run in every state, including ALARM.
            r_err_valid <= w_sample_corr;
            if (w_sample_corr) begin
                r_err_pos <= w_syn;
            end
            r_err_cnt <= w_err_cnt_nxt;

            if (valid_in) begin
                r_hist_valid  <= 1'b1;
                r_hist_cnt    <= count_in;
                r_hist_updown <= updown;
            end
            if (w_step_bad) begin
                r_seq_err <= 1'b1;
            end

            // Any alarm source wins over scrub activity; ALARM is absorbing.
            if (w_alarm_src || (r_state == ALARM)) begin
                r_state      <= ALARM;
                r_alarm      <= 1'b1;
                r_scrub_req  <= 1'b0;
                r_scrub_mask <= '0;
                r_timer      <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_sample_corr) begin
                            r_scrub_mask <= w_mask;
                            r_scrub_req  <= 1'b1;
                            r_timer      <= '0;
                            r_state      <= REQ;
                        end
                    end
                    REQ: begin
                        // The mask stays frozen while waiting. An error seen on
                        // the ack cycle is still in the stored word, so IDLE
                        // picks it up again on the next sample.
                        if (scrub_ack) begin
                            r_scrub_req  <= 1'b0;
                            r_scrub_mask <= '0;
                            r_state      <= IDLE;
                        end else begin
                            r_timer <= r_timer + TMR_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ALARM;
                        r_alarm <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign err_valid  = r_err_valid;
    assign err_pos    = r_err_pos;
    assign err_cnt    = r_err_cnt;
    assign scrub_req  = r_scrub_req;
    assign scrub_mask = r_scrub_mask;
    assign seq_err    = r_seq_err;
    assign alarm      = r_alarm;

endmodule

// File: tb/tb_ecc_fault_monitor.sv
// tb_ecc_fault_monitor: directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural model of the monitor.
module tb_ecc_fault_monitor;

    localparam int ERR_CNT_W    = 8;
    localparam int ALARM_THRESH = 16;
    localparam int ACK_TIMEOUT  = 15;
    localparam int ERR_MAX      = (1 << ERR_CNT_W) - 1;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [5:0]           code_in;
    logic [2:0]           count_in;
    logic                 updown;
    logic                 valid_in;
    logic                 scrub_ack;
    logic                 err_valid;
    logic [2:0]           err_pos;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic                 scrub_req;
    logic [5:0]           scrub_mask;
    logic                 seq_err;
    logic                 alarm;

    ecc_fault_monitor #(
        .ERR_CNT_W    (ERR_CNT_W),
        .ALARM_THRESH (ALARM_THRESH),
        .ACK_TIMEOUT  (ACK_TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .code_in    (code_in),
        .count_in   (count_in),
        .updown     (updown),
        .valid_in   (valid_in),
        .scrub_ack  (scrub_ack),
        .err_valid  (err_valid),
        .err_pos    (err_pos),
        .err_cnt    (err_cnt),
        .scrub_req  (scrub_req),
        .scrub_mask (scrub_mask),
        .seq_err    (seq_err),
        .alarm      (alarm)
    );

    always #5 clock = ~clock;

    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";

    // Behavioural model state.
    bit m_err_valid;
    int m_err_pos;
    int m_err_cnt;
    bit m_seq;
    bit m_alarm;
    bit m_req;
    int m_mask;
    int m_wait;
    int m_last;
    bit m_last_ud;

    // Stimulus state: the value the upstream counter currently holds.
    logic [2:0] b_count;
    logic       b_ud;

    // Hamming property: the syndrome is the XOR of the positions of all set bits.
    function automatic int syn_of(input logic [5:0] c);
        int s;
        s = 0;
        for (int i = 1; i <= 6; i++) begin
            if (c[i-1]) s = s ^ i;
        end
        return s;
    endfunction

    // Place q at positions 3,5,6 and choose parity so the word XORs to zero.
    function automatic logic [5:0] encode(input logic [2:0] q);
        logic [5:0] c;
        int         x;
        c    = 6'b0;
        c[2] = q[0];
        c[4] = q[1];
        c[5] = q[2];
        x    = syn_of(c);
        c[0] = x[0];
        c[1] = x[1];
        c[3] = x[2];
        return c;
    endfunction

    function automatic logic [5:0] flip_pos(input int pos);
        logic [5:0] f;
        f = 6'b0;
        f[pos-1] = 1'b1;
        return f;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic v, input logic [5:0] code, input logic [2:0] cnt,
                                input logic ud, input logic ack, input logic rst);
        int s;
        bit corr;
        bit fatal;
        int want;
        if (rst) begin
            m_err_valid = 0; m_err_pos = 0; m_err_cnt = 0; m_seq = 0; m_alarm = 0;
            m_req = 0; m_mask = 0; m_wait = 0; m_last = -1; m_last_ud = 0;
        end else begin
            s     = syn_of(code);
            corr  = v && (s >= 1) && (s <= 6);
            fatal = v && (s == 7);
            m_err_valid = corr;
            if (corr) begin
                m_err_pos = s;
                if (m_err_cnt < ERR_MAX) m_err_cnt++;
            end
            if (v) begin
                if (m_last >= 0) begin
                    want = m_last_ud ? (m_last + 1) % 8 : (m_last + 7) % 8;
                    if (int'(cnt) != want) begin
                        m_seq = 1;
                        fatal = 1;
                    end
                end
                m_last    = int'(cnt);
                m_last_ud = ud;
            end
            if (m_err_cnt >= ALARM_THRESH) fatal = 1;
            if (!m_alarm) begin
                if (m_req) begin
                    if (ack) begin
                        m_req  = 0;
                        m_mask = 0;
                    end else begin
                        m_wait++;
                        if (m_wait == ACK_TIMEOUT) fatal = 1;
                    end
                end else if (corr) begin
                    m_req  = 1;
                    m_mask = 1 << (s - 1);
                    m_wait = 0;
                end
            end
            if (fatal) begin
                m_alarm = 1;
                m_req   = 0;
                m_mask  = 0;
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, compare all outputs.
    task automatic tick(input logic v, input logic [5:0] code, input logic [2:0] cnt,
                        input logic ud, input logic ack, input logic rst);
        valid_in  = v;
        code_in   = code;
        count_in  = cnt;
        updown    = ud;
        scrub_ack = ack;
        reset     = rst;
        @(posedge clock);
        #1;
        model_update(v, code, cnt, ud, ack, rst);
        check("err_valid",  32'(err_valid),  32'(m_err_valid));
        check("err_pos",    32'(err_pos),    32'(m_err_pos));
        check("err_cnt",    32'(err_cnt),    32'(m_err_cnt));
        check("scrub_req",  32'(scrub_req),  32'(m_req));
        check("scrub_mask", 32'(scrub_mask), 32'(m_mask));
        check("seq_err",    32'(seq_err),    32'(m_seq));
        check("alarm",      32'(alarm),      32'(m_alarm));
    endtask

    task automatic do_reset();
        tick(1'b0, 6'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    endtask

    // First sample after reset: only loads the step history.
    task automatic load(input logic [2:0] q, input logic ud);
        b_count = q;
        b_ud    = ud;
        tick(1'b1, encode(b_count), b_count, b_ud, 1'b0, 1'b0);
    endtask

    // Legal counter step, optionally with bits of the stored word flipped.
    task automatic sample(input logic [5:0] flip, input logic ack);
        b_count = b_ud ? b_count + 3'd1 : b_count - 3'd1;
        tick(1'b1, encode(b_count) ^ flip, b_count, b_ud, ack, 1'b0);
    endtask

    task automatic idle(input logic ack);
        tick(1'b0, encode(b_count), b_count, b_ud, ack, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n_req;
        logic [5:0] flip;
        int         r;

        b_count = 3'd0;
        b_ud    = 1'b1;

        // Reset state.
        phase = "reset";
        do_reset();
        do_reset();
        check("alarm_rst", 32'(alarm), 32'd0);
        check("req_rst",   32'(scrub_req), 32'd0);

        // Clean up-count 0..7..0, plus an ack in IDLE that must be ignored.
        phase = "clean";
        load(3'd0, 1'b1);
        for (int i = 0; i < 8; i++) sample(6'b0, 1'b0);
        idle(1'b1);
        check("cnt_clean",  32'(err_cnt), 32'd0);
        check("seq_clean",  32'(seq_err), 32'd0);
        check("req_clean",  32'(scrub_req), 32'd0);
        check("pos_clean",  32'(err_pos), 32'd0);

        // Single upset of d5 at count 3, acked two cycles later.
        phase = "upset";
        do_reset();
        load(3'd0, 1'b1);
        sample(6'b0, 1'b0);
        sample(6'b0, 1'b0);
        sample(6'b010000, 1'b0);
        check("ev_upset",   32'(err_valid),  32'd1);
        check("pos_upset",  32'(err_pos),    32'd5);
        check("mask_upset", 32'(scrub_mask), 32'b010000);
        check("req_upset",  32'(scrub_req),  32'd1);
        idle(1'b0);
        check("ev_pulse",   32'(err_valid),  32'd0);
        check("req_held",   32'(scrub_req),  32'd1);
        idle(1'b1);
        check("req_acked",  32'(scrub_req),  32'd0);
        check("cnt_upset",  32'(err_cnt),    32'd1);

        // Upset of p2 never acked.
        phase = "timeout";
        do_reset();
        load(3'd4, 1'b0);
        sample(6'b000010, 1'b0);
        check("mask_to", 32'(scrub_mask), 32'b000010);
        n_req = scrub_req ? 1 : 0;
        for (int i = 0; i < 40 && scrub_req; i++) begin
            idle(1'b0);
            if (scrub_req) n_req++;
        end
        check("req_cycles", 32'(n_req), 32'(ACK_TIMEOUT));
        check("alarm_to",   32'(alarm), 32'd1);
        check("req_to",     32'(scrub_req), 32'd0);

        // Uncorrectable: p1, p2 and p4 flipped together give syndrome 7.
        phase = "uncorr";
        do_reset();
        load(3'd1, 1'b1);
        sample(6'b001011, 1'b0);
        check("alarm_unc", 32'(alarm), 32'd1);
        check("cnt_unc",   32'(err_cnt), 32'd0);
        check("req_unc",   32'(scrub_req), 32'd0);

        // Sequence fault 2 -> 4 counting up, then reset clears everything.
        phase = "seq";
        do_reset();
        load(3'd2, 1'b1);
        b_count = 3'd4;
        tick(1'b1, encode(b_count), b_count, 1'b1, 1'b0, 1'b0);
        check("seq_fault",   32'(seq_err), 32'd1);
        check("alarm_fault", 32'(alarm),   32'd1);
        do_reset();
        check("seq_cleared",   32'(seq_err), 32'd0);
        check("alarm_cleared", 32'(alarm),   32'd0);

        // Reset in the middle of a pending scrub request.
        phase = "rst_req";
        load(3'd6, 1'b1);
        sample(6'b000100, 1'b0);
        check("req_pending", 32'(scrub_req), 32'd1);
        do_reset();
        check("req_dropped", 32'(scrub_req), 32'd0);
        for (int i = 0; i < 3; i++) idle(1'b0);

        // Threshold at 16 acked upsets, then saturation at 255.
        phase = "sat";
        do_reset();
        load(3'd0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            sample(flip_pos(int'($urandom_range(1, 6))), 1'b0);
            if (k == 15) check("alarm_15", 32'(alarm), 32'd0);
            if (k == 16) begin
                check("alarm_16", 32'(alarm),   32'd1);
                check("cnt_16",   32'(err_cnt), 32'd16);
            end
            idle(1'b1);
        end
        for (int k = 17; k <= 262; k++) begin
            sample(flip_pos(int'($urandom_range(1, 6))), 1'b0);
        end
        check("cnt_sat", 32'(err_cnt), 32'(ERR_MAX));
        check("ev_sat",  32'(err_valid), 32'd1);

        // Randomized traffic in segments; direction is fixed within a segment.
        phase = "random";
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            load(3'($urandom_range(0, 7)), 1'(seg % 2));
            for (int i = 0; i < 80; i++) begin
                r = int'($urandom_range(0, 99));
                if (r < 70)      flip = 6'b0;
                else if (r < 95) flip = flip_pos(int'($urandom_range(1, 6)));
                else             flip = 6'($urandom_range(0, 63));
                r = int'($urandom_range(0, 99));
                if (r < 2) begin
                    b_count = b_count + 3'd2;
                    tick(1'b1, encode(b_count), b_count, b_ud, 1'b0, 1'b0);
                end else if (r < 70) begin
                    sample(flip, ($urandom_range(0, 3) == 0));
                end else begin
                    idle(($urandom_range(0, 2) == 0));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ecc_fault_monitor.md
Name: ecc_fault_monitor

Overview:
- Downstream companion to the Hamming-protected mod-8 counter. Every cycle it samples the stored 6-bit codeword and the corrected count.
- Recomputes the syndrome, logs and counts single-bit upsets, and checks that the count steps by exactly ±1 per update.
- Drives a req/ack scrub handshake so the counter's per-bit preset/reset logic can rewrite the upset register.
- Escalates to a sticky alarm on uncorrectable syndromes, sequence errors, error-count threshold or scrub timeout.

Parameters:
- ERR_CNT_W, 8, width of saturating corrected-error counter.
- ALARM_THRESH, 16, err_cnt value at or above which alarm asserts.
- ACK_TIMEOUT, 15, max cycles scrub_req may wait for scrub_ack before alarm.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- code_in  in  6  stored codeword, Hamming positions 6..1 = {d6,d5,p4,d3,p2,p1}.
- count_in  in  3  corrected count {q6,q5,q3}.
- updown  in  1  counter direction for this update (1 = up).
- valid_in  in  1  code_in/count_in are a new post-update sample.
- scrub_ack  in  1  upstream has rewritten the bits in scrub_mask.
- err_valid  out  1  one-cycle pulse, single-bit error logged.
- err_pos  out  3  syndrome (Hamming position 1..6) of last logged error.
- err_cnt  out  ERR_CNT_W  saturating corrected-error count.
- scrub_req  out  1  request to rewrite bits in scrub_mask.
- scrub_mask  out  6  one-hot bit to rewrite; bit i-1 = position i.
- seq_err  out  1  sticky, count step violation seen.
- alarm  out  1  sticky fatal indication.

Behaviour:
- Reset: all outputs 0. FSM in IDLE. Step-check history invalid.
- Syndrome, combinational on code_in:
  - s1 = p1^d3^d5, s2 = p2^d3^d6, s4 = p4^d5^d6.
  - syn = {s4,s2,s1}.
- All evaluation is gated by valid_in. Outputs are registered, so latency is 1 cycle from the valid_in sample.
- syn = 0: no error.
- syn in 1..6, correctable:
  - err_valid pulses for 1 cycle; err_pos <= syn.
  - err_cnt increments, saturating at 2^ERR_CNT_W-1.
- syn = 7 (no such position): alarm <= 1. Not counted. No scrub.
- Step check:
  - On each valid_in, store count_in and updown as the history.
  - On the next valid_in, require count_in == stored + 1 (updown = 1) or stored - 1 (updown = 0), mod 8. 7->0 and 0->7 are legal wraps.
  - On mismatch: seq_err <= 1 and alarm <= 1.
  - The first valid_in after reset only loads history.
- FSM IDLE, REQ, ALARM:
  - IDLE: on a correctable error, scrub_mask <= one-hot(syn), scrub_req <= 1, timer <= 0, go to REQ.
  - REQ: scrub_req held high; scrub_mask frozen. Errors arriving during REQ still pulse err_valid and count, but do not change the mask.
  - REQ, scrub_ack = 1: scrub_req <= 0, scrub_mask <= 0, return to IDLE. A new error in that same cycle is picked up in IDLE on the next valid_in, not dropped silently, because the counter is still counted.
  - REQ, scrub_ack = 0: timer increments. At timer == ACK_TIMEOUT, go to ALARM.
  - scrub_ack while in IDLE is ignored.
  - Any alarm source, from any state, goes to ALARM.
  - ALARM: alarm = 1, scrub_req = 0. Absorbing until reset. err_cnt and err_valid keep operating.
- Threshold: alarm asserts when err_cnt >= ALARM_THRESH.
- Reset asserted mid-REQ: scrub_req drops on the next edge; no ack is expected afterwards.

Decomposition:
- Shared package (ecc_pkg):
  - Codeword bit-position constants.
  - syndrome function.
  - FSM state enum {IDLE, REQ, ALARM}.
  - one-hot decode function.
- Syndrome plus one-hot mask generation forms one natural combinational sub-module, ecc_syndrome. The parity equations match the counter's parity generator.
- The FSM, counters and step check stay in the top.

Test Plan:
- Clean up-count: 0..7..0 with valid_in every cycle, zero codewords only. Required: err_cnt = 0, no scrub_req, seq_err = 0, wrap 7->0 accepted.
- Single upset: flip d5 (position 5) at count 3. Required: next cycle err_valid = 1, err_pos = 5, scrub_mask = 6'b010000, scrub_req = 1. scrub_ack 2 cycles later: scrub_req = 0 next cycle, err_cnt = 1.
- Ack timeout: upset p2 and never ack. Required: scrub_req held with scrub_mask = 6'b000010 for ACK_TIMEOUT cycles, then alarm = 1 and scrub_req = 0.
- Uncorrectable: inject syn = 7 by flipping p1, p2 and p4 together. Required: alarm = 1, err_cnt unchanged, no scrub_req.
- Sequence fault: count 2 -> 4 with updown = 1. Required: seq_err = 1 and alarm = 1 one cycle after the second sample. Then reset: all outputs 0 on the next edge.
- Saturation/threshold: 16 separate correctable upsets, each acked. Required: alarm asserts when err_cnt reaches 16. Continued upsets saturate err_cnt at 255.
